// File: rtl/sram_to_axi4_lite.sv
// Single-outstanding bridge from a word-addressed request/response port
// to an AXI4-Lite master interface.
module sram_to_axi4_lite #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           SRAM_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    localparam int unsigned          STRB_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                       AXI_CLK,
    input  logic                       RST,

    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic                       REQ_WE,
    input  logic [SRAM_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]      REQ_WDATA,
    input  logic [STRB_WIDTH-1:0]      REQ_WSTRB,

    output logic                       RSP_VALID,
    output logic [DATA_WIDTH-1:0]      RSP_RDATA,
    output logic                       RSP_ERR,

    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [ADDR_WIDTH-1:0]      AWADDR,
    output logic                       WVALID,
    input  logic                       WREADY,
    output logic [DATA_WIDTH-1:0]      WDATA,
    output logic [STRB_WIDTH-1:0]      WSTRB,
    input  logic                       BVALID,
    output logic                       BREADY,
    input  logic [1:0]                 BRESP,

    output logic                       ARVALID,
    input  logic                       ARREADY,
    output logic [ADDR_WIDTH-1:0]      ARADDR,
    input  logic                       RVALID,
    output logic                       RREADY,
    input  logic [DATA_WIDTH-1:0]      RDATA,
    input  logic [1:0]                 RRESP
);

    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_awvalid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_wvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_bready;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_rready;

    logic [ADDR_WIDTH-1:0]   w_req_byte_addr;
    logic                    w_aw_done;
    logic                    w_w_done;
    logic                    w_unused;

    // Word index scaled to bytes; the sum wraps modulo 2^ADDR_WIDTH.
    assign w_req_byte_addr = BASE_ADDR + (ADDR_WIDTH'(REQ_ADDR) << BYTE_SHIFT);

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid  || WREADY;

    // Only the error bit of the response code is reported.
    assign w_unused  = &{1'b0, BRESP[0], RRESP[0]};

    // Gated by RST so the port reads not-ready throughout reset and ready
    // as soon as reset is released.
    assign REQ_READY = (r_state == S_IDLE) && !RST;

    always_ff @(posedge AXI_CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        if (REQ_WE) begin
                            r_awaddr  <= w_req_byte_addr;
                            r_wdata   <= REQ_WDATA;
                            r_wstrb   <= REQ_WSTRB;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_araddr  <= w_req_byte_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (AWREADY) r_awvalid <= 1'b0;
                    if (WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= BRESP[1];
                        r_rsp_rdata <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= RRESP[1];
                        r_rsp_rdata <= RDATA;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_awaddr;
    assign WVALID    = r_wvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign BREADY    = r_bready;
    assign ARVALID   = r_arvalid;
    assign ARADDR    = r_araddr;
    assign RREADY    = r_rready;

endmodule

// File: tb/tb_sram_to_axi4_lite.sv
// Randomized self-checking bench for sram_to_axi4_lite: a bench-driven AXI
// slave with programmable delays and an arithmetic reference model.
module tb_sram_to_axi4_lite;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        AXI_CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_READY, REQ_WE;
    logic [7:0]  REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [3:0]  REQ_WSTRB;
    logic        RSP_VALID, RSP_ERR;
    logic [31:0] RSP_RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] ARADDR, RDATA;
    logic [1:0]  RRESP;

    // Narrow-address instance for wrap-around
    logic        x_REQ_VALID, x_REQ_READY, x_REQ_WE;
    logic [7:0]  x_REQ_ADDR;
    logic [31:0] x_REQ_WDATA;
    logic [3:0]  x_REQ_WSTRB;
    logic        x_RSP_VALID, x_RSP_ERR;
    logic [31:0] x_RSP_RDATA;
    logic        x_AWVALID, x_AWREADY, x_WVALID, x_WREADY, x_BVALID, x_BREADY;
    logic [7:0]  x_AWADDR, x_ARADDR;
    logic [31:0] x_WDATA, x_RDATA;
    logic [3:0]  x_WSTRB;
    logic [1:0]  x_BRESP, x_RRESP;
    logic        x_ARVALID, x_ARREADY, x_RVALID, x_RREADY;

    int errors = 0;
    int checks = 0;

    always #5 AXI_CLK = ~AXI_CLK;

    sram_to_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(8), .BASE_ADDR(BASE)) u_dut (
        .AXI_CLK(AXI_CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    sram_to_axi4_lite #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(8), .BASE_ADDR(8'hF0)) u_wrap (
        .AXI_CLK(AXI_CLK), .RST(RST),
        .REQ_VALID(x_REQ_VALID), .REQ_READY(x_REQ_READY), .REQ_WE(x_REQ_WE), .REQ_ADDR(x_REQ_ADDR),
        .REQ_WDATA(x_REQ_WDATA), .REQ_WSTRB(x_REQ_WSTRB),
        .RSP_VALID(x_RSP_VALID), .RSP_RDATA(x_RSP_RDATA), .RSP_ERR(x_RSP_ERR),
        .AWVALID(x_AWVALID), .AWREADY(x_AWREADY), .AWADDR(x_AWADDR),
        .WVALID(x_WVALID), .WREADY(x_WREADY), .WDATA(x_WDATA), .WSTRB(x_WSTRB),
        .BVALID(x_BVALID), .BREADY(x_BREADY), .BRESP(x_BRESP),
        .ARVALID(x_ARVALID), .ARREADY(x_ARREADY), .ARADDR(x_ARADDR),
        .RVALID(x_RVALID), .RREADY(x_RREADY), .RDATA(x_RDATA), .RRESP(x_RRESP)
    );

    // Reference: byte address of a request word, and error flag of a response code.
    function automatic logic [31:0] model_addr(input logic [7:0] a);
        return BASE + 32'(a) * 32'd4;
    endfunction

    function automatic logic model_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp,
                            output int aw_hi, output int w_hi);
        int cyc, bcnt, exp_lat;
        bit aw_done, w_done, aw_hs, w_hs, b_done, b_hs;
        logic [31:0] ea;
        ea = model_addr(a);
        exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_WDATA = d; REQ_WSTRB = s;
        #1;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL wr_req_ready got=%b exp=1", REQ_READY); end
        @(negedge AXI_CLK);
        REQ_VALID = 1'b0; REQ_WE = 1'($urandom); REQ_ADDR = 8'($urandom); REQ_WDATA = $urandom; REQ_WSTRB = 4'($urandom);
        cyc = 1; aw_done = 0; w_done = 0; aw_hi = 0; w_hi = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            checks++; if ({AWVALID, WVALID, BREADY, REQ_READY} !== {!aw_done, !w_done, 1'b0, 1'b0}) begin
                errors++; $display("FAIL wr_req_valids got=%b exp=%b", {AWVALID, WVALID, BREADY, REQ_READY}, {!aw_done, !w_done, 2'b00}); end
            if (!aw_done) begin
                checks++; if (AWADDR !== ea) begin errors++; $display("FAIL awaddr got=%h exp=%h", AWADDR, ea); end
            end
            if (!w_done) begin
                checks++; if ({WDATA, WSTRB} !== {d, s}) begin errors++; $display("FAIL wdata_wstrb got=%h/%h exp=%h/%h", WDATA, WSTRB, d, s); end
            end
            aw_hi += int'(AWVALID); w_hi += int'(WVALID);
            AWREADY = (cyc > aw_dly); WREADY = (cyc > w_dly);
            aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY;
            @(negedge AXI_CLK);
            AWREADY = 1'b0; WREADY = 1'b0;
            aw_done = aw_done || aw_hs; w_done = w_done || w_hs; cyc++;
        end
        checks++; if (aw_hi != aw_dly + 1 || w_hi != w_dly + 1) begin
            errors++; $display("FAIL valid_hold_cycles got=%0d/%0d exp=%0d/%0d", aw_hi, w_hi, aw_dly + 1, w_dly + 1); end
        bcnt = 0; b_done = 0;
        while (!b_done && cyc < 200) begin
            checks++; if ({BREADY, AWVALID, WVALID, RSP_VALID} !== 4'b1000) begin
                errors++; $display("FAIL wr_resp_phase got=%b exp=1000", {BREADY, AWVALID, WVALID, RSP_VALID}); end
            BVALID = (bcnt >= b_dly); BRESP = BVALID ? resp : 2'($urandom);
            b_hs = BVALID && BREADY;
            @(negedge AXI_CLK);
            BVALID = 1'b0; BRESP = 2'($urandom);
            b_done = b_hs; bcnt++; cyc++;
        end
        checks++; if (RSP_VALID !== 1'b1 || cyc != exp_lat) begin
            errors++; $display("FAIL wr_rsp_latency got=%b@%0d exp=1@%0d", RSP_VALID, cyc, exp_lat); end
        checks++; if ({RSP_ERR, RSP_RDATA, REQ_READY, BREADY} !== {model_err(resp), 32'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_rsp_fields got=%b/%h/%b exp=%b/0/1", RSP_ERR, RSP_RDATA, REQ_READY, model_err(resp)); end
        @(negedge AXI_CLK);
        checks++; if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b0, model_err(resp), 32'h0}) begin
            errors++; $display("FAIL wr_rsp_hold got=%b/%b/%h exp=0/%b/0", RSP_VALID, RSP_ERR, RSP_RDATA, model_err(resp)); end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] rd, input logic [1:0] resp,
                           input int ar_dly, input int r_dly);
        int cyc, rcnt, exp_lat;
        bit ar_done, ar_hs, r_done, r_hs;
        logic [31:0] ea;
        ea = model_addr(a);
        exp_lat = ar_dly + r_dly + 3;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = a;
        #1;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rd_req_ready got=%b exp=1", REQ_READY); end
        @(negedge AXI_CLK);
        REQ_VALID = 1'b0; REQ_ADDR = 8'($urandom);
        cyc = 1; ar_done = 0;
        while (!ar_done && cyc < 100) begin
            checks++; if ({ARVALID, RREADY, AWVALID, REQ_READY} !== 4'b1000 || ARADDR !== ea) begin
                errors++; $display("FAIL rd_req_phase got=%b/%h exp=1000/%h", {ARVALID, RREADY, AWVALID, REQ_READY}, ARADDR, ea); end
            ARREADY = (cyc > ar_dly);
            ar_hs = ARVALID && ARREADY;
            @(negedge AXI_CLK);
            ARREADY = 1'b0; ar_done = ar_hs; cyc++;
        end
        rcnt = 0; r_done = 0;
        while (!r_done && cyc < 200) begin
            checks++; if ({RREADY, ARVALID, RSP_VALID} !== 3'b100) begin
                errors++; $display("FAIL rd_resp_phase got=%b exp=100", {RREADY, ARVALID, RSP_VALID}); end
            RVALID = (rcnt >= r_dly);
            RDATA = RVALID ? rd : $urandom; RRESP = RVALID ? resp : 2'($urandom);
            r_hs = RVALID && RREADY;
            @(negedge AXI_CLK);
            RVALID = 1'b0; RDATA = $urandom; RRESP = 2'($urandom);
            r_done = r_hs; rcnt++; cyc++;
        end
        checks++; if (RSP_VALID !== 1'b1 || cyc != exp_lat) begin
            errors++; $display("FAIL rd_rsp_latency got=%b@%0d exp=1@%0d", RSP_VALID, cyc, exp_lat); end
        checks++; if ({RSP_ERR, RSP_RDATA, REQ_READY, RREADY} !== {model_err(resp), rd, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rd_rsp_fields got=%b/%h/%b exp=%b/%h/1", RSP_ERR, RSP_RDATA, REQ_READY, model_err(resp), rd); end
        @(negedge AXI_CLK);
        checks++; if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b0, model_err(resp), rd}) begin
            errors++; $display("FAIL rd_rsp_hold got=%b/%b/%h exp=0/%b/%h", RSP_VALID, RSP_ERR, RSP_RDATA, model_err(resp), rd); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge AXI_CLK);
        checks++; if ({REQ_READY, RSP_VALID, RSP_ERR, AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000000", {REQ_READY, RSP_VALID, RSP_ERR, AWVALID, WVALID, ARVALID, BREADY, RREADY}); end
        checks++; if ({AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA} !== '0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA); end
        RST = 1'b0;
        #1;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", REQ_READY); end
    endtask

    task automatic test_zero_wait();
        int aw_hi, w_hi;
        do_write(8'h05, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, aw_hi, w_hi);
        do_read(8'h05, $urandom, 2'b00, 0, 0);
    endtask

    task automatic test_aw_delay();
        int aw_hi, w_hi;
        do_write(8'($urandom), $urandom, 4'($urandom), 4, 0, 1, 2'b00, aw_hi, w_hi);
        checks++; if (aw_hi != 5 || w_hi != 1) begin
            errors++; $display("FAIL aw_delay_hold got=%0d/%0d exp=5/1", aw_hi, w_hi); end
        do_write(8'($urandom), $urandom, 4'($urandom), 0, 3, 0, 2'b11, aw_hi, w_hi);
        checks++; if (aw_hi != 1 || w_hi != 4) begin
            errors++; $display("FAIL w_delay_hold got=%0d/%0d exp=1/4", aw_hi, w_hi); end
    endtask

    task automatic test_read_err();
        do_read(8'hFF, 32'h1234_5678, 2'b10, 2, 0);
        do_read(8'h00, 32'hCAFE_0001, 2'b01, 1, 2);
    endtask

    task automatic test_strb_zero();
        int aw_hi, w_hi;
        do_write(8'h3C, 32'hA5A5_5A5A, 4'h0, 0, 1, 0, 2'b00, aw_hi, w_hi);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ra, wa;
        logic [31:0] rd, wd;
        logic [3:0]  ws;
        ra = 8'($urandom); wa = 8'($urandom); rd = $urandom; wd = $urandom; ws = 4'($urandom);
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = rd; RRESP = 2'b00;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = ra;
        @(negedge AXI_CLK);
        REQ_WE = 1'b1; REQ_ADDR = wa; REQ_WDATA = wd; REQ_WSTRB = ws;
        checks++; if ({ARVALID, ARADDR, REQ_READY} !== {1'b1, model_addr(ra), 1'b0}) begin
            errors++; $display("FAIL b2b_ar got=%b/%h/%b exp=1/%h/0", ARVALID, ARADDR, REQ_READY, model_addr(ra)); end
        @(negedge AXI_CLK);
        checks++; if ({RREADY, REQ_READY, RSP_VALID} !== 3'b100) begin
            errors++; $display("FAIL b2b_rresp got=%b exp=100", {RREADY, REQ_READY, RSP_VALID}); end
        @(negedge AXI_CLK);
        checks++; if ({RSP_VALID, REQ_READY, RSP_RDATA} !== {2'b11, rd}) begin
            errors++; $display("FAIL b2b_first_rsp got=%b%b/%h exp=11/%h", RSP_VALID, REQ_READY, RSP_RDATA, rd); end
        @(negedge AXI_CLK);
        REQ_VALID = 1'b0;
        checks++; if ({AWVALID, WVALID, RSP_VALID, AWADDR, WDATA, WSTRB} !== {3'b110, model_addr(wa), wd, ws}) begin
            errors++; $display("FAIL b2b_second_accept got=%b%b%b/%h/%h exp=110/%h/%h", AWVALID, WVALID, RSP_VALID, AWADDR, WDATA, model_addr(wa), wd); end
        repeat (2) @(negedge AXI_CLK);
        checks++; if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL b2b_second_rsp got=%b%b/%h exp=10/0", RSP_VALID, RSP_ERR, RSP_RDATA); end
        ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        @(negedge AXI_CLK);
    endtask

    task automatic test_reset_mid();
        int aw_hi, w_hi, pulses;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'($urandom); REQ_WDATA = $urandom; REQ_WSTRB = 4'hF;
        @(negedge AXI_CLK);
        REQ_VALID = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
        @(negedge AXI_CLK);
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        checks++; if (BREADY !== 1'b1) begin errors++; $display("FAIL rst_mid_in_wr_resp got=%b exp=1", BREADY); end
        RST = 1'b1;
        @(negedge AXI_CLK);
        checks++; if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, REQ_READY} !== 7'h00) begin
            errors++; $display("FAIL rst_mid_outputs got=%b exp=0000000", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, REQ_READY}); end
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge AXI_CLK);
            pulses += int'(RSP_VALID);
        end
        checks++; if (pulses != 0 || REQ_READY !== 1'b1) begin
            errors++; $display("FAIL rst_mid_abandon got=%0d/%b exp=0/1", pulses, REQ_READY); end
        do_write(8'($urandom), $urandom, 4'($urandom), 1, 0, 2, 2'b00, aw_hi, w_hi);
    endtask

    task automatic test_wrap();
        logic [7:0]  a;
        logic [31:0] rd;
        int unsigned e;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 8'h08 : 8'($urandom);
            rd = $urandom;
            e = (32'd240 + 32'(a) * 32'd4) % 32'd256;
            x_REQ_VALID = 1'b1; x_REQ_WE = 1'b0; x_REQ_ADDR = a;
            @(negedge AXI_CLK);
            x_REQ_VALID = 1'b0;
            checks++; if ({x_ARVALID, x_ARADDR} !== {1'b1, 8'(e)}) begin
                errors++; $display("FAIL wrap_araddr got=%b/%h exp=1/%h", x_ARVALID, x_ARADDR, 8'(e)); end
            x_ARREADY = 1'b1;
            @(negedge AXI_CLK);
            x_ARREADY = 1'b0; x_RVALID = 1'b1; x_RDATA = rd; x_RRESP = 2'b00;
            @(negedge AXI_CLK);
            x_RVALID = 1'b0;
            checks++; if ({x_RSP_VALID, x_RSP_RDATA} !== {1'b1, rd}) begin
                errors++; $display("FAIL wrap_rsp got=%b/%h exp=1/%h", x_RSP_VALID, x_RSP_RDATA, rd); end
            @(negedge AXI_CLK);
        end
    endtask

    task automatic test_random();
        int aw_hi, w_hi;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), 2'($urandom), aw_hi, w_hi);
            else
                do_read(8'($urandom), $urandom, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        x_REQ_VALID = 1'b0; x_REQ_WE = 1'b0; x_REQ_ADDR = '0; x_REQ_WDATA = '0; x_REQ_WSTRB = '0;
        x_AWREADY = 1'b0; x_WREADY = 1'b0; x_BVALID = 1'b0; x_BRESP = '0;
        x_ARREADY = 1'b0; x_RVALID = 1'b0; x_RDATA = '0; x_RRESP = '0;
        test_reset();
        test_zero_wait();
        test_aw_delay();
        test_read_err();
        test_strb_zero();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1, "timeout");
    end

endmodule
